uio_bus_arbiter: RTL and testbench

// - Shares the 8-bit bidirectional uio pad bus (uio_in/uio_out/uio_oe) between NREQ internal requesters.
// - Arbitrates round-robin and grants one requester a burst of write or read beats.
// - Drives uio_oe per beat and returns sampled read data to the owner.
// - Sits between the top-level tt_um_* pad ports and the user logic blocks.

---
 rtl/uio_bus_arbiter.sv | 255 +++++++++++++++++++++++++
 tb/tb_uio_bus_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uio_bus_arbiter.sv
// ---------------------------------------------------------------------------
// uio_bus_arbiter
//   Shares the 8-bit bidirectional uio pad bus between NREQ internal
//   requesters. A round-robin arbiter grants one requester a burst of
//   same-direction beats (write or read). Write beats drive uio_out/uio_oe.
//   Read beats sample uio_in into rd_data and pulse rd_valid for the owner.
//
//   Optional feature macro: UIO_ARB_TURNAROUND_EN
//     When defined, a grant whose direction differs from the previous burst
//     spends one TURN cycle with the pads released before the first beat.
//
// Ports
//   clk        clock
//   rst        synchronous reset, active-high
//   ena        design enable; low forces IDLE and releases the pads
//   req_valid  per-requester beat request
//   req_write  per-requester direction, 1 = write, 0 = read
//   req_last   per-requester final-beat marker
//   req_wdata  write bytes, requester i on [8i+7:8i]
//   req_ack    beat accepted (combinational, one-hot)
//   rd_data    registered sample of uio_in
//   rd_valid   one-hot pulse marking rd_data for that requester
//   uio_in     pad input path
//   uio_out    pad output path (registered)
//   uio_oe     pad enable, 8'hFF drive / 8'h00 input (registered)
//   busy       arbiter is not idle
//   owner      current or most recent grant index
// ---------------------------------------------------------------------------
module uio_bus_arbiter #(
   parameter  int NREQ      = 4,
   parameter  int MAX_BURST = 4,
   localparam int OW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ena,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [NREQ-1:0]     req_write,
   input  logic [NREQ-1:0]     req_last,
   input  logic [8*NREQ-1:0]   req_wdata,
   output logic [NREQ-1:0]     req_ack,
   output logic [7:0]          rd_data,
   output logic [NREQ-1:0]     rd_valid,
   input  logic [7:0]          uio_in,
   output logic [7:0]          uio_out,
   output logic [7:0]          uio_oe,
   output logic                busy,
   output logic [OW-1:0]       owner
);

`ifdef UIO_ARB_TURNAROUND_EN
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_TURN = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1
   } state_t;
`endif

   // Index of the requester after idx, wrapping at NREQ.
   function automatic logic [OW-1:0] next_index(input logic [OW-1:0] idx);
      if (int'(idx) == NREQ - 1) begin
         return {OW{1'b0}};
      end else begin
         return idx + {{(OW-1){1'b0}}, 1'b1};
      end
   endfunction

   state_t            state_r;
   state_t            state_next_s;
   logic [OW-1:0]     owner_r;
   logic              dir_r;
   logic              last_dir_r;
   logic [OW-1:0]     rr_ptr_r;
   logic [3:0]        beat_cnt_r;
   logic [7:0]        uio_out_r;
   logic [7:0]        uio_oe_r;
   logic [7:0]        rd_data_r;
   logic [NREQ-1:0]   rd_valid_r;

   logic              found_s;
   logic [OW-1:0]     pick_s;
   logic [OW-1:0]     cand_s;
   int                cand_v;
   logic              grant_s;
   logic              end_s;
   logic              wr_beat_s;
   logic              rd_beat_s;
   logic [NREQ-1:0]   ack_s;
   logic              own_valid_s;
   logic              own_write_s;
   logic              own_last_s;
   logic [7:0]        wdata_s;

   assign own_valid_s = req_valid[owner_r];
   assign own_write_s = req_write[owner_r];
   assign own_last_s  = req_last[owner_r];
   assign wdata_s     = req_wdata[{owner_r, 3'b000} +: 8];

   assign req_ack  = ack_s;
   assign rd_data  = rd_data_r;
   assign rd_valid = rd_valid_r;
   assign uio_out  = uio_out_r;
   assign uio_oe   = uio_oe_r;
   assign busy     = (state_r != ST_IDLE);
   assign owner    = owner_r;

   // Round-robin search: first requesting index at or after the pointer.
   always_comb begin
      found_s = 1'b0;
      pick_s  = rr_ptr_r;
      cand_v  = 0;
      cand_s  = {OW{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         cand_v = int'(rr_ptr_r) + i;
         if (cand_v >= NREQ) begin
            cand_v = cand_v - NREQ;
         end else begin
            cand_v = cand_v;
         end
         cand_s = OW'(cand_v);
         if (!found_s && req_valid[cand_s]) begin
            found_s = 1'b1;
            pick_s  = cand_s;
         end else begin
            found_s = found_s;
         end
      end
   end

   // Next-state, acknowledge and beat strobes.
   always_comb begin
      state_next_s = state_r;
      ack_s        = {NREQ{1'b0}};
      grant_s      = 1'b0;
      end_s        = 1'b0;
      wr_beat_s    = 1'b0;
      rd_beat_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (ena && found_s) begin
               grant_s = 1'b1;
`ifdef UIO_ARB_TURNAROUND_EN
               if (req_write[pick_s] != last_dir_r) begin
                  state_next_s = ST_TURN;
               end else begin
                  state_next_s = ST_XFER;
               end
`else
               state_next_s = ST_XFER;
`endif
            end else begin
               state_next_s = ST_IDLE;
            end
         end
`ifdef UIO_ARB_TURNAROUND_EN
         ST_TURN: begin
            if (ena) begin
               state_next_s = ST_XFER;
            end else begin
               // Aborted before any beat; still counts as a finished grant.
               end_s        = 1'b1;
               state_next_s = ST_IDLE;
            end
         end
`endif
         ST_XFER: begin
            if (!ena) begin
               end_s        = 1'b1;
               state_next_s = ST_IDLE;
            end else if (!own_valid_s || (own_write_s != dir_r)) begin
               // Owner withdrew or turned around: close without acking.
               end_s        = 1'b1;
               state_next_s = ST_IDLE;
            end else begin
               ack_s[owner_r] = 1'b1;
               wr_beat_s      = own_write_s;
               rd_beat_s      = !own_write_s;
               if (own_last_s || (beat_cnt_r == 4'(MAX_BURST - 1))) begin
                  end_s        = 1'b1;
                  state_next_s = ST_IDLE;
               end else begin
                  state_next_s = ST_XFER;
               end
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Grant bookkeeping, pad drivers and read-data capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner_r    <= {OW{1'b0}};
         dir_r      <= 1'b0;
         last_dir_r <= 1'b0;
         rr_ptr_r   <= {OW{1'b0}};
         beat_cnt_r <= 4'd0;
         uio_out_r  <= 8'h00;
         uio_oe_r   <= 8'h00;
         rd_data_r  <= 8'h00;
         rd_valid_r <= {NREQ{1'b0}};
      end else begin
         rd_valid_r <= ack_s & {NREQ{rd_beat_s}};
         if (grant_s) begin
            owner_r <= pick_s;
            dir_r   <= req_write[pick_s];
            // A read grant releases the pads immediately; a write grant
            // keeps whatever a previous write burst left on the bus.
            if (!req_write[pick_s]) begin
               uio_oe_r <= 8'h00;
            end
         end
`ifdef UIO_ARB_TURNAROUND_EN
         if (state_next_s == ST_TURN) begin
            uio_oe_r <= 8'h00;
         end
`endif
         if (wr_beat_s) begin
            uio_out_r <= wdata_s;
            uio_oe_r  <= 8'hFF;
         end
         if (rd_beat_s) begin
            uio_oe_r  <= 8'h00;
            rd_data_r <= uio_in;
         end
         if (!ena) begin
            uio_oe_r <= 8'h00;
         end
         if (end_s) begin
            beat_cnt_r <= 4'd0;
            last_dir_r <= dir_r;
            rr_ptr_r   <= next_index(owner_r);
         end else if (|ack_s) begin
            beat_cnt_r <= beat_cnt_r + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_uio_bus_arbiter.sv
module tb_uio_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        ena;
   logic [3:0]  req_valid;
   logic [3:0]  req_write;
   logic [3:0]  req_last;
   logic [31:0] req_wdata;
   logic [3:0]  req_ack;
   logic [7:0]  rd_data;
   logic [3:0]  rd_valid;
   logic [7:0]  uio_in;
   logic [7:0]  uio_out;
   logic [7:0]  uio_oe;
   logic        busy;
   logic [1:0]  owner;

   int n_vec  = 0;
   int n_miss = 0;

   uio_bus_arbiter #(.NREQ(4), .MAX_BURST(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .ena       (ena),
      .req_valid (req_valid),
      .req_write (req_write),
      .req_last  (req_last),
      .req_wdata (req_wdata),
      .req_ack   (req_ack),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .uio_in    (uio_in),
      .uio_out   (uio_out),
      .uio_oe    (uio_oe),
      .busy      (busy),
      .owner     (owner)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [1:0]  exp_order [5];
      logic [31:0] rr_wdata;
      logic [3:0]  ack_exp;
      logic [7:0]  byte_exp;

      exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      rr_wdata  = 32'h4332_2110;

      rst = 1'b1; ena = 1'b0;
      req_valid = 4'b0000; req_write = 4'b0000; req_last = 4'b0000;
      req_wdata = 32'h0000_0000; uio_in = 8'h00;
      tick(); tick();

      // reset state
      chk("rst_uio_out",  32'(uio_out),  32'h00);
      chk("rst_uio_oe",   32'(uio_oe),   32'h00);
      chk("rst_rd_data",  32'(rd_data),  32'h00);
      chk("rst_rd_valid", 32'(rd_valid), 32'h0);
      chk("rst_owner",    32'(owner),    32'h0);
      chk("rst_busy",     32'(busy),     32'h0);
      chk("rst_ack",      32'(req_ack),  32'h0);
      rst = 1'b0; ena = 1'b1;

      // single write from requester 0
      req_valid = 4'b0001; req_write = 4'b0001; req_last = 4'b0001;
      req_wdata = 32'h0000_00A5;
      #1;
      chk("w1_idle_ack",  32'(req_ack), 32'h0);
      chk("w1_idle_busy", 32'(busy),    32'h0);
      tick();
      chk("w1_busy",  32'(busy),    32'h1);
      chk("w1_owner", 32'(owner),   32'h0);
      chk("w1_ack",   32'(req_ack), 32'h1);
      tick();
      req_valid = 4'b0000; #1;
      chk("w1_uio_out", 32'(uio_out), 32'hA5);
      chk("w1_uio_oe",  32'(uio_oe),  32'hFF);
      chk("w1_busy_lo", 32'(busy),    32'h0);
      chk("w1_ack_lo",  32'(req_ack), 32'h0);

      // three-beat read burst from requester 2
      req_valid = 4'b0100; req_write = 4'b0000; req_last = 4'b0000; uio_in = 8'h11;
      tick();
      chk("rd_owner", 32'(owner),   32'h2);
      chk("rd_oe0",   32'(uio_oe),  32'h00);
      chk("rd_ack0",  32'(req_ack), 32'h4);
      tick();
      uio_in = 8'h22; #1;
      chk("rd_data1",  32'(rd_data),  32'h11);
      chk("rd_valid1", 32'(rd_valid), 32'h4);
      chk("rd_ack1",   32'(req_ack),  32'h4);
      tick();
      uio_in = 8'h33; req_last = 4'b0100; #1;
      chk("rd_data2",  32'(rd_data),  32'h22);
      chk("rd_valid2", 32'(rd_valid), 32'h4);
      chk("rd_oe2",    32'(uio_oe),   32'h00);
      tick();
      req_valid = 4'b0000; req_last = 4'b0000; #1;
      chk("rd_data3",  32'(rd_data),  32'h33);
      chk("rd_valid3", 32'(rd_valid), 32'h4);
      chk("rd_busy3",  32'(busy),     32'h0);
      chk("rd_oe3",    32'(uio_oe),   32'h00);
      tick();
      chk("rd_valid_end", 32'(rd_valid), 32'h0);

      // reset between tests, then round-robin over four single writes
      rst = 1'b1; tick(); rst = 1'b0;
      chk("rst2_rd_data", 32'(rd_data), 32'h00);
      req_valid = 4'b1111; req_write = 4'b1111; req_last = 4'b1111; req_wdata = rr_wdata;
      for (int k = 0; k < 5; k++) begin
         tick();
         ack_exp = 4'b0001 << exp_order[k];
         chk("rr_owner", 32'(owner),   32'(exp_order[k]));
         chk("rr_ack",   32'(req_ack), 32'(ack_exp));
         tick();
         if (k == 4) begin
            req_valid = 4'b0000; #1;
         end
         byte_exp = 8'(rr_wdata >> (8 * int'(exp_order[k])));
         chk("rr_uio_out", 32'(uio_out), 32'(byte_exp));
         chk("rr_idle_ack", 32'(req_ack), 32'h0);
      end

      // MAX_BURST: requester 1 never raises last while requester 3 waits
      req_valid = 4'b1010; req_write = 4'b1010; req_last = 4'b0000; req_wdata = 32'hB300_A100;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("mb_owner", 32'(owner),   32'h1);
         chk("mb_ack",   32'(req_ack), 32'h2);
      end
      tick();
      chk("mb_idle_ack",  32'(req_ack), 32'h0);
      chk("mb_idle_busy", 32'(busy),    32'h0);
      chk("mb_uio_out",   32'(uio_out), 32'hA1);
      tick();
      chk("mb_owner3", 32'(owner),   32'h3);
      chk("mb_ack3",   32'(req_ack), 32'h8);
      tick();
      req_valid = 4'b0000; #1;
      chk("mb_drop_ack",  32'(req_ack), 32'h0);
      chk("mb_drop_busy", 32'(busy),    32'h1);
      chk("mb_uio_out3",  32'(uio_out), 32'hB3);
      tick();
      chk("mb_end_busy", 32'(busy), 32'h0);

      // write burst from requester 0 followed by a read from requester 1
      req_valid = 4'b0011; req_write = 4'b0001; req_last = 4'b0000; req_wdata = 32'h0000_00C1;
      tick();
      chk("ta_owner0", 32'(owner),   32'h0);
      chk("ta_ack_b1", 32'(req_ack), 32'h1);
      tick();
      req_last = 4'b0001; #1;
      chk("ta_ack_b2", 32'(req_ack), 32'h1);
      tick();
      req_valid = 4'b0010; req_write = 4'b0000; req_last = 4'b0010; uio_in = 8'h77; #1;
      chk("ta_gap_busy", 32'(busy),    32'h0);
      chk("ta_gap_ack",  32'(req_ack), 32'h0);
      chk("ta_keep_out", 32'(uio_out), 32'hC1);
      chk("ta_keep_oe",  32'(uio_oe),  32'hFF);
      tick();
      chk("ta_owner1", 32'(owner),   32'h1);
      chk("ta_rd_ack", 32'(req_ack), 32'h2);
      chk("ta_rd_oe",  32'(uio_oe),  32'h00);
      tick();
      req_valid = 4'b0000; req_last = 4'b0000; #1;
      chk("ta_rd_valid", 32'(rd_valid), 32'h2);
      chk("ta_rd_data",  32'(rd_data),  32'h77);
      chk("ta_end_busy", 32'(busy),     32'h0);

      // ena dropped on the second beat of a requester-2 write burst
      req_valid = 4'b0100; req_write = 4'b0100; req_last = 4'b0000; req_wdata = 32'h005A_0000;
      tick();
      chk("en_owner", 32'(owner),   32'h2);
      chk("en_ack1",  32'(req_ack), 32'h4);
      tick();
      ena = 1'b0; #1;
      chk("en_no_ack", 32'(req_ack), 32'h0);
      chk("en_out_b1", 32'(uio_out), 32'h5A);
      chk("en_oe_b1",  32'(uio_oe),  32'hFF);
      tick();
      chk("en_oe_off", 32'(uio_oe),  32'h00);
      chk("en_busy",   32'(busy),    32'h0);
      chk("en_ack_lo", 32'(req_ack), 32'h0);
      req_valid = 4'b0000; ena = 1'b1;
      tick();

      // rst asserted on the second beat of the same burst
      req_valid = 4'b0100; uio_in = 8'h00;
      tick();
      chk("rs_owner", 32'(owner),   32'h2);
      chk("rs_ack1",  32'(req_ack), 32'h4);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; req_valid = 4'b0000; #1;
      chk("rs_uio_out",  32'(uio_out),  32'h00);
      chk("rs_uio_oe",   32'(uio_oe),   32'h00);
      chk("rs_rd_data",  32'(rd_data),  32'h00);
      chk("rs_rd_valid", 32'(rd_valid), 32'h0);
      chk("rs_owner0",   32'(owner),    32'h0);
      chk("rs_busy",     32'(busy),     32'h0);
      chk("rs_ack",      32'(req_ack),  32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
